y86_fetch_seq: RTL and testbench

//  Instruction fetch engine for the SEQ Y86-64 core; the consumer of the PC produced by pc_update.

---
 rtl/y86_pkg.sv | 27 ++
 rtl/y86_instr_len.sv | 37 +++
 rtl/y86_fetch_seq.sv | 191 +++++++++++++++++++
 tb/tb_y86_fetch_seq.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared icode constants, register sentinel and fetch state encoding
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_FETCH_OP    = 3'd1,
        S_FETCH_REG   = 3'd2,
        S_FETCH_CONST = 3'd3,
        S_DONE        = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/y86_instr_len.sv
// rtl/y86_instr_len.sv - icode to instruction length and format decoder
module y86_instr_len
    import y86_pkg::*;
(
    input  logic [3:0] icode_i,
    output logic [3:0] len_o,
    output logic       need_regs_o,
    output logic       need_valc_o,
    output logic       valid_o
);

    // Unknown icodes report length 1 so valP = pc + len_o still holds for them
    always_comb begin
        len_o       = 4'd1;
        need_regs_o = 1'b0;
        need_valc_o = 1'b0;
        valid_o     = 1'b1;
        case (icode_i)
            I_HALT, I_NOP, I_RET: ;
            I_CMOVXX, I_OPQ, I_PUSHQ, I_POPQ: begin
                len_o       = 4'd2;
                need_regs_o = 1'b1;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                len_o       = 4'd10;
                need_regs_o = 1'b1;
                need_valc_o = 1'b1;
            end
            I_JXX, I_CALL: begin
                len_o       = 4'd9;
                need_valc_o = 1'b1;
            end
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/y86_fetch_seq.sv
// rtl/y86_fetch_seq.sv - byte-serial Y86-64 instruction fetch engine with req/ack memory port
module y86_fetch_seq
    import y86_pkg::*;
#(
    parameter int IMEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] pc,
    output logic        ready,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        instr_valid,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        imem_error,
    output logic        instr_invalid
);

    fetch_state_e state_q;
    logic        ready_q, mem_req_q, instr_valid_q, imem_error_q, instr_invalid_q;
    logic [63:0] mem_addr_q, pc_q, valc_q, valp_q, valc_w_q;
    logic [3:0]  icode_q, ifun_q, ra_q, rb_q;
    logic [3:0]  icode_w_q, ifun_w_q, ra_w_q, rb_w_q;
    logic [2:0]  cnt_q;

    logic [3:0]  cur_icode, len;
    logic        need_regs, need_valc, len_valid;
    logic [63:0] nxt_addr;
    logic        addr_bad, pc_bad, last_byte;
    logic [3:0]  wk_icode, wk_ifun, wk_ra, wk_rb;
    logic [63:0] wk_valc;

    assign cur_icode = (state_q == S_FETCH_OP) ? mem_rdata[7:4] : icode_w_q;

    y86_instr_len u_len (
        .icode_i     (cur_icode),
        .len_o       (len),
        .need_regs_o (need_regs),
        .need_valc_o (need_valc),
        .valid_o     (len_valid)
    );

    assign nxt_addr = mem_addr_q + 64'd1;
    assign addr_bad = nxt_addr >= 64'(IMEM_SIZE);
    assign pc_bad   = pc >= 64'(IMEM_SIZE);

    // Working fields as they would look once the byte on mem_rdata is absorbed
    always_comb begin
        wk_icode = icode_w_q;
        wk_ifun  = ifun_w_q;
        wk_ra    = ra_w_q;
        wk_rb    = rb_w_q;
        wk_valc  = valc_w_q;
        last_byte = 1'b0;
        case (state_q)
            S_FETCH_OP: begin
                wk_icode  = mem_rdata[7:4];
                wk_ifun   = mem_rdata[3:0];
                last_byte = !len_valid || (len == 4'd1);
            end
            S_FETCH_REG: begin
                wk_ra     = mem_rdata[7:4];
                wk_rb     = mem_rdata[3:0];
                last_byte = !need_valc;
            end
            S_FETCH_CONST: begin
                wk_valc[{cnt_q, 3'b000} +: 8] = mem_rdata;
                last_byte = (cnt_q == 3'd7);
            end
            default: ;
        endcase
    end

    // Fetch FSM: accepts a PC, walks the bytes, publishes decoded fields on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            ready_q         <= 1'b1;
            mem_req_q       <= 1'b0;
            mem_addr_q      <= 64'd0;
            instr_valid_q   <= 1'b0;
            icode_q         <= 4'h0;
            ifun_q          <= 4'h0;
            ra_q            <= REG_NONE;
            rb_q            <= REG_NONE;
            valc_q          <= 64'd0;
            valp_q          <= 64'd0;
            imem_error_q    <= 1'b0;
            instr_invalid_q <= 1'b0;
            pc_q            <= 64'd0;
            icode_w_q       <= 4'h0;
            ifun_w_q        <= 4'h0;
            ra_w_q          <= REG_NONE;
            rb_w_q          <= REG_NONE;
            valc_w_q        <= 64'd0;
            cnt_q           <= 3'd0;
        end else begin
            instr_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pc_q            <= pc;
                        icode_w_q       <= 4'h0;
                        ifun_w_q        <= 4'h0;
                        ra_w_q          <= REG_NONE;
                        rb_w_q          <= REG_NONE;
                        valc_w_q        <= 64'd0;
                        cnt_q           <= 3'd0;
                        ready_q         <= 1'b0;
                        imem_error_q    <= 1'b0;
                        instr_invalid_q <= 1'b0;
                        if (pc_bad) begin
                            // Nothing fetchable: icode unknown, so length is taken as 1
                            state_q       <= S_DONE;
                            instr_valid_q <= 1'b1;
                            icode_q       <= 4'h0;
                            ifun_q        <= 4'h0;
                            ra_q          <= REG_NONE;
                            rb_q          <= REG_NONE;
                            valc_q        <= 64'd0;
                            valp_q        <= pc + 64'd1;
                            imem_error_q  <= 1'b1;
                        end else begin
                            state_q    <= S_FETCH_OP;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= pc;
                        end
                    end
                end
                S_FETCH_OP, S_FETCH_REG, S_FETCH_CONST: begin
                    if (mem_ack) begin
                        icode_w_q <= wk_icode;
                        ifun_w_q  <= wk_ifun;
                        ra_w_q    <= wk_ra;
                        rb_w_q    <= wk_rb;
                        valc_w_q  <= wk_valc;
                        if (last_byte || addr_bad) begin
                            state_q         <= S_DONE;
                            mem_req_q       <= 1'b0;
                            instr_valid_q   <= 1'b1;
                            icode_q         <= wk_icode;
                            ifun_q          <= wk_ifun;
                            ra_q            <= wk_ra;
                            rb_q            <= wk_rb;
                            valc_q          <= wk_valc;
                            valp_q          <= pc_q + 64'(len);
                            imem_error_q    <= !last_byte;
                            instr_invalid_q <= !len_valid;
                        end else begin
                            mem_addr_q <= nxt_addr;
                            if (state_q == S_FETCH_CONST) cnt_q <= cnt_q + 3'd1;
                            state_q <= (state_q == S_FETCH_OP && need_regs) ? S_FETCH_REG
                                                                            : S_FETCH_CONST;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q   <= S_IDLE;
                    ready_q   <= 1'b1;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready         = ready_q;
    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_addr_q;
    assign instr_valid   = instr_valid_q;
    assign icode         = icode_q;
    assign ifun          = ifun_q;
    assign rA            = ra_q;
    assign rB            = rb_q;
    assign valC          = valc_q;
    assign valP          = valp_q;
    assign imem_error    = imem_error_q;
    assign instr_invalid = instr_invalid_q;

endmodule

// File: tb/tb_y86_fetch_seq.sv
// tb/tb_y86_fetch_seq.sv - scoreboard bench for the Y86-64 fetch engine
module tb_y86_fetch_seq;

    localparam int IMEM_SIZE = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] pc = 64'd0;
    logic        ready, mem_req, instr_valid, imem_error, instr_invalid;
    logic [63:0] mem_addr, valC, valP;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;
    logic [3:0]  icode, ifun, rA, rB;

    y86_fetch_seq #(.IMEM_SIZE(IMEM_SIZE)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .pc            (pc),
        .ready         (ready),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .instr_valid   (instr_valid),
        .icode         (icode),
        .ifun          (ifun),
        .rA            (rA),
        .rB            (rB),
        .valC          (valC),
        .valP          (valP),
        .imem_error    (imem_error),
        .instr_invalid (instr_invalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic        ierr, iinv;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sbq[$];
    logic [63:0] aq[$];
    logic [7:0]  imem [0:IMEM_SIZE-1];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wait_n = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                                input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp,
                                input logic ie, input logic ii, input int lat);
        exp_t e;
        e.icode = ic; e.ifun = fn; e.ra = ra; e.rb = rb;
        e.valc = vc; e.valp = vp; e.ierr = ie; e.iinv = ii;
        e.lat = lat; e.acc = 0;
        return e;
    endfunction

    initial begin
        for (int i = 0; i < IMEM_SIZE; i++) imem[i] = 8'h00;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // memory responder plus address checks
    initial begin : responder
        int wcnt;
        logic pw;
        logic [63:0] pa;
        logic [63:0] ea;
        wcnt = 0; pw = 1'b0; pa = 64'd0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req && !rst) begin
                if (pw) chk("addr_stable", mem_addr, pa);
                chk("addr_in_range", {63'd0, mem_addr < 64'(IMEM_SIZE)}, 64'd1);
                mem_rdata = (mem_addr < 64'(IMEM_SIZE)) ? imem[mem_addr[9:0]] : 8'h00;
                if (wcnt < wait_n) begin
                    wcnt++;
                    pw = 1'b1;
                    pa = mem_addr;
                end else begin
                    wcnt = 0;
                    pw = 1'b0;
                    mem_ack = 1'b1;
                    if (aq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_req: got addr %0h want no request", mem_addr);
                    end else begin
                        ea = aq.pop_front();
                        chk("mem_addr", mem_addr, ea);
                    end
                end
            end else begin
                wcnt = 0;
                pw = 1'b0;
            end
        end
    end

    // output monitor
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && instr_valid) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_valid: got pulse icode=%0h want none", icode);
                end else begin
                    e = sbq.pop_front();
                    chk("icode", 64'(icode), 64'(e.icode));
                    chk("ifun", 64'(ifun), 64'(e.ifun));
                    chk("rA", 64'(rA), 64'(e.ra));
                    chk("rB", 64'(rB), 64'(e.rb));
                    chk("valC", valC, e.valc);
                    chk("valP", valP, e.valp);
                    chk("imem_error", 64'(imem_error), 64'(e.ierr));
                    chk("instr_invalid", 64'(instr_invalid), 64'(e.iinv));
                    chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
                end
            end
        end
    end

    task automatic wait_ready();
        int t;
        t = 0;
        while (!ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!ready) begin
            total++; bad++;
            $display("FAIL ready_timeout: got ready=0 want 1");
        end
    endtask

    task automatic issue(input logic [63:0] a, input int nload, input logic [79:0] b,
                         input int nfetch, input bit do_chk, input exp_t e);
        exp_t ee;
        wait_ready();
        for (int k = 0; k < nload; k++) imem[10'(a + 64'(k))] = b[79-8*k -: 8];
        for (int k = 0; k < nfetch; k++) aq.push_back(a + 64'(k));
        ee = e;
        ee.acc = cyc + 1;
        if (do_chk) sbq.push_back(ee);
        start = 1'b1;
        pc = a;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    localparam logic [79:0] B_IRMOV = 80'h30F3EFCDAB8967452301;
    localparam logic [79:0] B_JMP   = 80'h74000100000000000000;

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_icode", 64'(icode), 64'd0);
        chk("rst_rA", 64'(rA), 64'hF);
        chk("rst_rB", 64'(rB), 64'hF);
        chk("rst_valC", valC, 64'd0);
        chk("rst_valP", valP, 64'd0);
        chk("rst_flags", {62'd0, imem_error, instr_invalid}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // irmovq, zero-wait
        issue(64'h0, 10, B_IRMOV, 10, 1'b1,
              mk(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 64'd10, 1'b0, 1'b0, 11));
        wait_ready();
        repeat (3) @(negedge clk);
        chk("hold_valC", valC, 64'h0123456789ABCDEF);
        chk("hold_valP", valP, 64'd10);

        // jXX
        issue(64'h20, 9, B_JMP, 9, 1'b1,
              mk(4'h7, 4'h4, 4'hF, 4'hF, 64'h100, 64'h29, 1'b0, 1'b0, 10));

        // halt then ret
        issue(64'h5, 1, 80'h00 << 72, 1, 1'b1,
              mk(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd6, 1'b0, 1'b0, 2));
        issue(64'h6, 1, 80'h90 << 72, 1, 1'b1,
              mk(4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'd7, 1'b0, 1'b0, 2));

        // OPq with three wait cycles per byte
        wait_ready();
        wait_n = 3;
        issue(64'h40, 2, 80'h6012 << 64, 2, 1'b1,
              mk(4'h6, 4'h0, 4'h1, 4'h2, 64'd0, 64'h42, 1'b0, 1'b0, 9));
        wait_ready();
        wait_n = 0;

        // invalid icode, then fetch running off the end of memory
        issue(64'h10, 1, 80'hC0 << 72, 1, 1'b1,
              mk(4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'h11, 1'b0, 1'b1, 2));
        issue(64'(IMEM_SIZE - 1), 1, 80'h30 << 72, 1, 1'b1,
              mk(4'h3, 4'h0, 4'hF, 4'hF, 64'd0, 64'(IMEM_SIZE - 1 + 10), 1'b1, 1'b0, 2));

        // reset in the middle of the constant bytes
        issue(64'h100, 10, B_IRMOV, 10, 1'b0,
              mk(4'h3, 4'h0, 4'hF, 4'h3, 64'd0, 64'd0, 1'b0, 1'b0, 0));
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_mem_req", 64'(mem_req), 64'd0);
        chk("async_ready", 64'(ready), 64'd1);
        chk("async_valid", 64'(instr_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        aq.delete();
        repeat (3) @(negedge clk);

        // start while busy must be ignored
        wait_n = 1;
        issue(64'h200, 9, B_JMP, 9, 1'b1,
              mk(4'h7, 4'h4, 4'hF, 4'hF, 64'h100, 64'h209, 1'b0, 1'b0, 19));
        repeat (3) @(negedge clk);
        start = 1'b1;
        pc = 64'h40;
        @(negedge clk);
        start = 1'b0;
        wait_ready();
        wait_n = 0;

        repeat (6) @(negedge clk);
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        chk("addr_drained", 64'(aq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
